// File: rtl/zz_pkg.sv
// Shared constants and types for the zz line packer and its downstream stage.
package zz_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned WORDS     = 16;
  localparam int unsigned LINE_W    = WORD_W * WORDS;
  localparam int unsigned TIMER_W   = 7;
  localparam int unsigned TIMER_MAX = (1 << TIMER_W) - 1;
  localparam int unsigned IDX_W     = $clog2(WORDS);
  localparam int unsigned CNT_W     = IDX_W + 1;

  typedef enum logic {StFill, StHold} state_e;

endpackage

// File: rtl/zz_stall_timer.sv
// Saturating up-counter with synchronous clear and enable; flags saturation.
module zz_stall_timer #(
  parameter int unsigned Width = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic sat_o
);

  logic [Width-1:0] count_q, count_d;

  assign sat_o = &count_q;

  // Clear wins over enable so a clear on the entry edge always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !sat_o) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/zz_line_packer.sv
// Packs 32-bit words into a 512-bit line, presents it with a one-cycle
// selection pulse and holds it until the consumer accepts.
module zz_line_packer
  import zz_pkg::*;
(
  input  logic              sysclk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              line_valid,
  input  logic              line_ready,
  output logic [LINE_W-1:0] line_data,
  output logic [CNT_W-1:0]  line_words,
  output logic              selection,
  output logic              stall
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORDS - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  wr_idx_q;
  logic [LINE_W-1:0] line_data_q;
  logic [CNT_W-1:0]  line_words_q;
  logic              line_valid_q;
  logic              selection_q;

  logic hold;
  logic accept;
  logic close;
  logic timer_sat;

  assign hold     = (state_q == StHold);
  // Gated by reset so the source sees no ready while the block is held in reset.
  assign in_ready = (state_q == StFill) && reset;
  assign accept   = in_valid && in_ready;
  assign close    = accept && ((wr_idx_q == LastIdx) || in_last);

  zz_stall_timer #(
    .Width (TIMER_W)
  ) u_stall_timer (
    .clk_i  (sysclk),
    .rst_ni (reset),
    .clr_i  (close || (hold && line_ready)),
    .en_i   (hold && !line_ready),
    .sat_o  (timer_sat)
  );

  assign stall      = timer_sat && hold;
  assign line_valid = line_valid_q;
  assign line_data  = line_data_q;
  assign line_words = line_words_q;
  assign selection  = selection_q;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q      <= StFill;
      wr_idx_q     <= '0;
      line_data_q  <= '0;
      line_words_q <= '0;
      line_valid_q <= 1'b0;
      selection_q  <= 1'b0;
    end else begin
      selection_q <= 1'b0;
      case (state_q)
        StFill: begin
          if (accept) begin
            line_data_q[WORD_W*wr_idx_q +: WORD_W] <= in_data;
            if (close) begin
              line_words_q <= {1'b0, wr_idx_q} + CNT_W'(1);
              wr_idx_q     <= '0;
              state_q      <= StHold;
              line_valid_q <= 1'b1;
              selection_q  <= 1'b1;
            end else begin
              wr_idx_q <= wr_idx_q + IDX_W'(1);
            end
          end
        end
        StHold: begin
          if (line_ready) begin
            // Clearing here zero-pads the unwritten slots of the next line.
            state_q      <= StFill;
            line_valid_q <= 1'b0;
            line_data_q  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zz_line_packer.sv
// Randomized self-checking bench for zz_line_packer against a queue-based line model.
module tb_zz_line_packer;
  import zz_pkg::*;

  logic              sysclk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              line_valid;
  logic              line_ready = 1'b0;
  logic [LINE_W-1:0] line_data;
  logic [4:0]        line_words;
  logic              selection;
  logic              stall;

  int checks = 0;
  int errors = 0;
  logic [WORD_W-1:0] q[$];

  zz_line_packer dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_data  (line_data),
    .line_words (line_words),
    .selection  (selection),
    .stall      (stall)
  );

  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // Expected line: accepted words in order from slot 0, everything else zero.
  function automatic logic [LINE_W-1:0] model_line();
    logic [LINE_W-1:0] l;
    l = '0;
    foreach (q[i]) l[WORD_W*i +: WORD_W] = q[i];
    return l;
  endfunction

  task automatic test_reset();
    #3;
    checks++;
    if (in_ready !== 1'b0 || line_valid !== 1'b0 || selection !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b v=%b sel=%b st=%b want 0000",
               in_ready, line_valid, selection, stall);
    end
    checks++;
    if (line_data !== '0 || line_words !== 5'd0) begin
      errors++;
      $display("FAIL reset_line got words=%0d data=%h want 0", line_words, line_data);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_full_line();
    logic [LINE_W-1:0] exp;
    q.delete();
    line_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      in_last  = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || line_valid !== 1'b0) begin
        errors++;
        $display("FAIL full_fill word %0d got rdy=%b v=%b want 1 0", i, in_ready, line_valid);
      end
      q.push_back(32'(i));
      step();
    end
    in_valid = 1'b0;
    exp = model_line();
    checks++;
    if (line_valid !== 1'b1 || selection !== 1'b1) begin
      errors++;
      $display("FAIL full_valid got v=%b sel=%b want 1 1", line_valid, selection);
    end
    checks++;
    if (line_words !== 5'd16 || line_data[511:480] !== 32'h0000000F) begin
      errors++;
      $display("FAIL full_words got words=%0d top=%h want 16 0000000f",
               line_words, line_data[511:480]);
    end
    checks++;
    if (line_data !== exp) begin
      errors++;
      $display("FAIL full_data got %h want %h", line_data, exp);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || line_valid !== 1'b0 || selection !== 1'b0) begin
      errors++;
      $display("FAIL full_release got rdy=%b v=%b sel=%b want 1 0 0",
               in_ready, line_valid, selection);
    end
    line_ready = 1'b0;
    q.delete();
  endtask

  task automatic test_early_close();
    logic [LINE_W-1:0] exp;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = (i == 2);
      q.push_back(in_data);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp = model_line();
    checks++;
    if (line_words !== 5'd3 || line_valid !== 1'b1) begin
      errors++;
      $display("FAIL early_words got words=%0d v=%b want 3 1", line_words, line_valid);
    end
    checks++;
    if (line_data !== exp) begin
      errors++;
      $display("FAIL early_data got %h want %h", line_data, exp);
    end
    step();
    checks++;
    if (selection !== 1'b0 || line_valid !== 1'b1 || line_data !== exp) begin
      errors++;
      $display("FAIL early_hold got sel=%b v=%b want 0 1", selection, line_valid);
    end
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    q.delete();
  endtask

  task automatic test_backpressure();
    logic [LINE_W-1:0] exp;
    q.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = 1'b0;
      q.push_back(in_data);
      step();
    end
    exp = model_line();
    for (int k = 0; k < 200; k++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = 1'($urandom);
      checks++;
      if (in_ready !== 1'b0 || line_valid !== 1'b1 || selection !== (k == 0)) begin
        errors++;
        $display("FAIL bp_ctrl cycle %0d got rdy=%b v=%b sel=%b want 0 1 %b",
                 k, in_ready, line_valid, selection, (k == 0));
      end
      checks++;
      if (stall !== (k >= 127)) begin
        errors++;
        $display("FAIL bp_stall cycle %0d got %b want %b", k, stall, (k >= 127));
      end
      checks++;
      if (line_data !== exp) begin
        errors++;
        $display("FAIL bp_data cycle %0d got %h want %h", k, line_data, exp);
      end
      step();
    end
    in_valid   = 1'b0;
    in_last    = 1'b0;
    line_ready = 1'b1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall_held got %b want 1", stall);
    end
    step();
    line_ready = 1'b0;
    checks++;
    if (stall !== 1'b0 || in_ready !== 1'b1 || line_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got st=%b rdy=%b v=%b want 0 1 0", stall, in_ready, line_valid);
    end
    q.delete();
  endtask

  task automatic test_source_stall();
    logic [LINE_W-1:0] exp;
    q.delete();
    for (int cyc = 0; cyc < 64 && q.size() < 16; cyc++) begin
      in_valid = (cyc % 2 == 0);
      in_data  = $urandom;
      if (in_valid) q.push_back(in_data);
      step();
    end
    in_valid = 1'b0;
    exp = model_line();
    checks++;
    if (line_valid !== 1'b1 || line_words !== 5'd16) begin
      errors++;
      $display("FAIL src_words got v=%b words=%0d want 1 16", line_valid, line_words);
    end
    checks++;
    if (line_data !== exp) begin
      errors++;
      $display("FAIL src_data got %h want %h", line_data, exp);
    end
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    q.delete();
  endtask

  task automatic test_single_word();
    logic [LINE_W-1:0] exp;
    q.delete();
    in_valid = 1'b1;
    in_data  = $urandom;
    in_last  = 1'b1;
    q.push_back(in_data);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp = model_line();
    checks++;
    if (line_words !== 5'd1 || selection !== 1'b1 || line_data !== exp) begin
      errors++;
      $display("FAIL single_line got words=%0d sel=%b data=%h want 1 1 %h",
               line_words, selection, line_data, exp);
    end
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || line_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release got rdy=%b v=%b want 1 0", in_ready, line_valid);
    end
    q.delete();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = (i == 1);
      q.push_back(in_data);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp = model_line();
    checks++;
    if (line_words !== 5'd2 || line_data !== exp) begin
      errors++;
      $display("FAIL single_next got words=%0d data=%h want 2 %h", line_words, line_data, exp);
    end
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    q.delete();
  endtask

  task automatic test_reset_mid();
    logic [LINE_W-1:0] exp;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom | 32'h1;
      step();
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b0 || line_data !== '0 || line_words !== 5'd0 || line_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b v=%b words=%0d data=%h want 0 0 0 0",
               in_ready, line_valid, line_words, line_data);
    end
    step();
    step();
    reset = 1'b1;
    q.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      q.push_back(in_data);
      step();
    end
    in_valid = 1'b0;
    exp = model_line();
    checks++;
    if (line_words !== 5'd16 || line_data !== exp) begin
      errors++;
      $display("FAIL mid_line got words=%0d data=%h want 16 %h", line_words, line_data, exp);
    end
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    q.delete();
  endtask

  task automatic test_random();
    logic [LINE_W-1:0] exp;
    int unsigned len;
    int unsigned gaps;
    int unsigned dly;
    for (int n = 0; n < 25; n++) begin
      q.delete();
      len = $urandom_range(1, 16);
      for (int unsigned i = 0; i < len; i++) begin
        gaps = $urandom_range(0, 2);
        for (int unsigned g = 0; g < gaps; g++) begin
          in_valid   = 1'b0;
          in_data    = $urandom;
          line_ready = 1'($urandom);
          step();
        end
        in_valid   = 1'b1;
        in_data    = $urandom;
        in_last    = (i == len - 1) && (len < 16 || 1'($urandom));
        line_ready = 1'($urandom);
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL rand_ready line %0d word %0d got %b want 1", n, i, in_ready);
        end
        q.push_back(in_data);
        step();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      exp = model_line();
      checks++;
      if (line_valid !== 1'b1 || selection !== 1'b1 || line_words !== 5'(len)) begin
        errors++;
        $display("FAIL rand_line %0d got v=%b sel=%b words=%0d want 1 1 %0d",
                 n, line_valid, selection, line_words, len);
      end
      checks++;
      if (line_data !== exp) begin
        errors++;
        $display("FAIL rand_data %0d got %h want %h", n, line_data, exp);
      end
      dly = $urandom_range(0, 3);
      for (int unsigned d = 0; d < dly; d++) begin
        line_ready = 1'b0;
        step();
        checks++;
        if (selection !== 1'b0 || line_valid !== 1'b1 || line_data !== exp) begin
          errors++;
          $display("FAIL rand_hold %0d got sel=%b v=%b want 0 1", n, selection, line_valid);
        end
      end
      line_ready = 1'b1;
      step();
      line_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || line_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_release %0d got rdy=%b v=%b want 1 0", n, in_ready, line_valid);
      end
    end
    q.delete();
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_early_close();
    test_backpressure();
    test_source_stall();
    test_single_word();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
